diff_result_serializer: RTL and testbench

Output-side companion of the `different` gradient unit. It captures the unit's three packed result vectors (`diff_start_out`, `diff_to_all_out`, `diff_dense_out`) on a load strobe. It then streams them out one `data_size`-bit word per transfer over a valid/ready handshake, tagged with vector and element index. This is the transmit end of the packed-vector convention used to feed `x` and `weight` into the unit. Downstream it feeds result logging and the weight-update path.

---
 rtl/diff_result_serializer.sv | 141 ++++++++++++++
 tb/tb_diff_result_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_result_serializer.sv
// diff_result_serializer
// Captures the three packed result vectors of the `different` gradient unit
// on a load strobe, then streams them out one element per valid/ready
// transfer, tagged with vector number and element index.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   load                capture request, honoured only when not sending
//   diff_start_in       packed start-gradient vector  (element 0 = MSB slice)
//   diff_to_all_in      packed to-all-gradient vector
//   diff_dense_in       packed dense-gradient vector
//   busy                high while a frame is being sent
//   out_valid/out_ready stream handshake
//   out_data            current element
//   out_vec             0=start, 1=to_all, 2=dense
//   out_idx             element index within the vector
//   out_last            high with the final word (vec 2, idx size-1)
//   done                one-cycle pulse after the final transfer
//   state_dbg           current FSM state for observation
//
// Handshake: a word moves at a rising edge where out_valid and out_ready are
// both high. Once out_valid rises it stays high, and every out_* field stays
// stable, until that word has moved. out_valid does not depend on out_ready.
module diff_result_serializer #(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [size*data_size-1:0] diff_start_in,
  input  logic [size*data_size-1:0] diff_to_all_in,
  input  logic [size*data_size-1:0] diff_dense_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_size-1:0]      out_data,
  output logic [1:0]                out_vec,
  output logic [7:0]                out_idx,
  output logic                      out_last,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(size - 1);

  state_t                    state_q, state_d;
  logic [size*data_size-1:0] sh_start_q, sh_to_all_q, sh_dense_q;
  logic [1:0]                vec_q;
  logic [7:0]                idx_q;

  logic                      load_accept;
  logic                      xfer;
  logic                      at_last;
  logic [size*data_size-1:0] sel_vec;
  logic [data_size-1:0]      sel_word;

  // DONE accepts a load just like IDLE so frames can run back to back.
  assign load_accept = load && (state_q != ST_SEND);
  assign xfer        = (state_q == ST_SEND) && out_ready;
  assign at_last     = (vec_q == 2'd2) && (idx_q == LAST_IDX);

  // Element selection from the shadow copies only.
  always_comb begin
    sel_vec = '0;
    case (vec_q)
      2'd0:    sel_vec = sh_start_q;
      2'd1:    sel_vec = sh_to_all_q;
      default: sel_vec = sh_dense_q;
    endcase
    sel_word = sel_vec[(size - 1 - int'(idx_q)) * data_size +: data_size];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_accept) state_d = ST_SEND;
      ST_SEND: if (xfer && at_last) state_d = ST_DONE;
      ST_DONE: state_d = load_accept ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_start_q  <= '0;
      sh_to_all_q <= '0;
      sh_dense_q  <= '0;
      vec_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q <= state_d;
      if (load_accept) begin
        sh_start_q  <= diff_start_in;
        sh_to_all_q <= diff_to_all_in;
        sh_dense_q  <= diff_dense_in;
        vec_q       <= '0;
        idx_q       <= '0;
      end else if (xfer) begin
        if (at_last) begin
          vec_q <= '0;
          idx_q <= '0;
        end else if (idx_q == LAST_IDX) begin
          vec_q <= vec_q + 2'd1;
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + 8'd1;
        end
      end
    end
  end

  // Stream fields read zero outside SEND so idle and reset outputs are clean.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_vec   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    state_dbg = state_q;
    if (state_q == ST_SEND) begin
      busy      = 1'b1;
      out_valid = 1'b1;
      out_data  = sel_word;
      out_vec   = vec_q;
      out_idx   = idx_q;
      out_last  = at_last;
    end
    if (state_q == ST_DONE) done = 1'b1;
  end

endmodule

// File: tb/tb_diff_result_serializer.sv
module tb_diff_result_serializer;

  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int VW = SZ * DS;
  localparam int NW = 3 * SZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [VW-1:0] diff_start_in = '0;
  logic [VW-1:0] diff_to_all_in = '0;
  logic [VW-1:0] diff_dense_in = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DS-1:0] out_data;
  logic [1:0]    out_vec;
  logic [7:0]    out_idx;
  logic          out_last;
  logic          done;
  logic [1:0]    state_dbg;

  diff_result_serializer #(.data_size(DS), .size(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .diff_start_in(diff_start_in), .diff_to_all_in(diff_to_all_in),
    .diff_dense_in(diff_dense_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_vec(out_vec), .out_idx(out_idx),
    .out_last(out_last), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame contents as plain element arrays, and the stream
  // they must produce as {last, vec, idx, data}.
  logic [DS-1:0] frame_el[3][SZ];
  logic [26:0]   exp_q[$];
  logic [26:0]   obs_q[$];
  int            hold_err, drop_err, done_cyc, timeout, stall_cnt;

  task automatic build_exp();
    exp_q.delete();
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < SZ; c++)
        exp_q.push_back({(v == 2 && c == SZ - 1), 2'(v), 8'(c), frame_el[v][c]});
  endtask

  task automatic random_frame();
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < SZ; c++) frame_el[v][c] = DS'($urandom);
  endtask

  task automatic spec_frame();
    for (int c = 0; c < SZ; c++) begin
      frame_el[0][c] = 16'h0001 + 16'(c);
      frame_el[1][c] = 16'h0011 + 16'(c);
      frame_el[2][c] = 16'h0021 + 16'(c);
    end
  endtask

  // Drives inputs from frame_el and holds load across one edge.
  task automatic load_frame();
    for (int c = 0; c < SZ; c++) begin
      diff_start_in[(SZ - c) * DS - 1 -: DS]  = frame_el[0][c];
      diff_to_all_in[(SZ - c) * DS - 1 -: DS] = frame_el[1][c];
      diff_dense_in[(SZ - c) * DS - 1 -: DS]  = frame_el[2][c];
    end
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    build_exp();
  endtask

  // Runs the sink until done is seen (or budget expires), collecting
  // transferred words. Called #1 after an edge. spam keeps load high with
  // all-ones inputs for every SEND cycle, final transfer edge included.
  task automatic run_stream(input int ready_pct, input bit spam);
    logic [26:0] prev;
    bit          stalled;
    int          cyc;
    obs_q.delete();
    hold_err = 0; drop_err = 0; timeout = 0; stall_cnt = 0;
    stalled = 1'b0; prev = '0; cyc = 0;
    forever begin
      if (done) break;
      if (!out_valid) drop_err++;
      if (stalled && {out_last, out_vec, out_idx, out_data} !== prev) hold_err++;
      out_ready = ($urandom_range(99) < ready_pct);
      if (spam) begin
        load = 1'b1;
        diff_start_in = '1; diff_to_all_in = '1; diff_dense_in = '1;
      end
      prev = {out_last, out_vec, out_idx, out_data};
      if (out_valid && out_ready) obs_q.push_back(prev);
      stalled = out_valid && !out_ready;
      if (stalled) stall_cnt++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin timeout = 1; break; end
    end
    load = 1'b0;
    out_ready = 1'b0;
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, out_valid, out_last, done, out_data, out_vec, out_idx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%0b valid=%0b last=%0b done=%0b data=%h vec=%0d idx=%0d, need all 0",
               busy, out_valid, out_last, done, out_data, out_vec, out_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream(input bit fixed);
    if (fixed) spec_frame(); else random_frame();
    load_frame();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== frame_el[0][0]) begin
      failures++;
      $display("FAIL stream_first_word: busy=%0b valid=%0b data=%h, need 1 1 %h",
               busy, out_valid, out_data, frame_el[0][0]);
    end
    run_stream(100, 1'b0);
    checks++;
    if (timeout != 0 || obs_q.size() != NW) begin
      failures++;
      $display("FAIL stream_count: timeout=%0d words=%0d, need 0 %0d", timeout, obs_q.size(), NW);
    end
    for (int i = 0; i < NW && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stream_word[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc != NW || drop_err != 0) begin
      failures++;
      $display("FAIL stream_timing: done after %0d cycles, valid drops=%0d, need %0d 0",
               done_cyc, drop_err, NW);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_done_pulse: done=%0b busy=%0b valid=%0b a cycle later, need 0 0 0",
               done, busy, out_valid);
    end
  endtask

  task automatic test_backpressure(input int ready_pct);
    spec_frame();
    load_frame();
    run_stream(ready_pct, 1'b0);
    checks++;
    if (timeout != 0 || obs_q.size() != NW) begin
      failures++;
      $display("FAIL bp_count: timeout=%0d words=%0d, need 0 %0d", timeout, obs_q.size(), NW);
    end
    for (int i = 0; i < NW && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_word[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_err != 0 || drop_err != 0 || done_cyc != NW + stall_cnt) begin
      failures++;
      $display("FAIL bp_hold_timing: hold_err=%0d drops=%0d done_cyc=%0d, need 0 0 %0d",
               hold_err, drop_err, done_cyc, NW + stall_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_load();
    random_frame();
    load_frame();
    run_stream(70, 1'b1);
    checks++;
    if (timeout != 0 || obs_q.size() != NW || done_cyc != NW + stall_cnt) begin
      failures++;
      $display("FAIL ign_count: timeout=%0d words=%0d done_cyc=%0d, need 0 %0d %0d",
               timeout, obs_q.size(), done_cyc, NW, NW + stall_cnt);
    end
    for (int i = 0; i < NW && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ign_word[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ign_no_new_frame: busy=%0b valid=%0b, need 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    random_frame();
    load_frame();
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, out_last, done, out_data, out_vec, out_idx} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%0b valid=%0b data=%h vec=%0d idx=%0d, need all 0",
               busy, out_valid, out_data, out_vec, out_idx);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    spec_frame();
    load_frame();
    run_stream(100, 1'b0);
    checks++;
    if (timeout != 0 || obs_q.size() != NW) begin
      failures++;
      $display("FAIL midrst_count: timeout=%0d words=%0d, need 0 %0d", timeout, obs_q.size(), NW);
    end
    for (int i = 0; i < NW && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midrst_word[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    random_frame();
    load_frame();
    run_stream(100, 1'b0);
    // Now inside the DONE cycle: load the next frame straight away.
    random_frame();
    frame_el[0][0] = 16'hFFFF;
    frame_el[0][1] = 16'h8000;
    frame_el[0][2] = 16'h7FFF;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_done: done=%0b, need 1", done);
    end
    load_frame();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_vec !== 2'd0 || out_idx !== 8'd0) begin
      failures++;
      $display("FAIL b2b_first: valid=%0b data=%h vec=%0d idx=%0d, need 1 ffff 0 0",
               out_valid, out_data, out_vec, out_idx);
    end
    run_stream(100, 1'b0);
    checks++;
    if (timeout != 0 || obs_q.size() != NW || done_cyc != NW) begin
      failures++;
      $display("FAIL b2b_count: timeout=%0d words=%0d done_cyc=%0d, need 0 %0d %0d",
               timeout, obs_q.size(), done_cyc, NW, NW);
    end
    for (int i = 0; i < NW && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_word[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream(1'b1);
    repeat (3) test_stream(1'b0);
    test_backpressure(50);
    test_backpressure(30);
    test_ignored_load();
    test_reset_mid_stream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
